mips_hazard_unit: RTL
=====================

MIPS_HAZARD_UNIT -- requirements
Module: mips_hazard_unit

Interface
REQ-001 The block SHALL have exactly one clock and one asynchronous, active-high reset, with ports as follows:
  clk  in  1  rising-edge clock
  reset  in  1  asynchronous, active-high reset
REQ-002 The block SHALL have the following data ports:
  MemReadEX  in  1  instruction in EX is a load
  RegWriteEX  in  1  instruction in EX writes a register
  WriteRegEX  in  5  destination register of the EX instruction
  MemReadMEM  in  1  instruction in MEM is a load
  WriteRegMEM  in  5  destination register of the MEM instruction
  RsID  in  5  Rs field of the ID instruction
  RtID  in  5  Rt field of the ID instruction
  UsesRtID  in  1  ID instruction reads Rt as a source
  BranchID  in  1  ID instruction is a branch resolved in ID
  FlushID  in  1  ID instruction is being squashed this cycle
  Stall  out  1  bubble request to the control-signal mux (1 = zero ID control signals)
  PCWrite  out  1  PC update enable
  IFIDWrite  out  1  IF/ID register write enable
  StallCount  out  32  saturating count of stall cycles (present only under REQ-021)

Function
REQ-003 The block SHALL define a source match srcM(r) = (r != 0) and ((r == RsID) or (UsesRtID and r == RtID)).
REQ-004 The block SHALL detect a load-use hazard as MemReadEX and srcM(WriteRegEX), requiring 1 stall cycle.
REQ-005 The block SHALL detect a branch-ALU hazard as BranchID and RegWriteEX and not MemReadEX and srcM(WriteRegEX), requiring 1 stall cycle.
REQ-006 The block SHALL detect a branch-load-EX hazard as BranchID and MemReadEX and srcM(WriteRegEX), requiring 2 stall cycles.
REQ-007 The block SHALL detect a branch-load-MEM hazard as BranchID and MemReadMEM and srcM(WriteRegMEM), requiring 1 stall cycle.
REQ-008 The FSM SHALL have two states, IDLE and HOLD, and SHALL reset to IDLE.
REQ-009 In IDLE, the block SHALL drive Stall combinationally as the OR of REQ-004 to REQ-007 in the same cycle, with zero added latency.
REQ-010 The transition IDLE->HOLD SHALL occur when REQ-006 is true and FlushID=0; in all other cases IDLE SHALL remain IDLE.
REQ-011 In HOLD, the block SHALL force Stall=1 regardless of the detect terms and SHALL then return unconditionally to IDLE the next cycle.
REQ-012 When FlushID=1, the block SHALL force Stall=0 and the next state SHALL be IDLE; FlushID SHALL override both detection and HOLD.
REQ-013 PCWrite and IFIDWrite SHALL each equal not Stall at all times.
REQ-014 Register 0 as a destination SHALL never cause a stall.
REQ-015 When several hazard terms are true simultaneously, the block SHALL stall for the longest required duration only (2 cycles maximum), never their sum.
REQ-016 The block SHALL contain no combinational path from Stall back into detection.

Reset
REQ-017 While reset=1, the block SHALL hold the state at IDLE, force Stall=0, and drive PCWrite=1 and IFIDWrite=1; when enabled, StallCount SHALL be 0.
REQ-018 Reset asserted in HOLD SHALL abort the second stall cycle immediately.
REQ-019 After reset deasserts, the first clock edge SHALL be evaluated from IDLE.

Configuration
REQ-020 Without HAZARD_STALL_COUNT_EN, the StallCount port and its logic SHALL be absent.
REQ-021 With HAZARD_STALL_COUNT_EN defined, StallCount SHALL increment by 1 on every clock edge where Stall=1, saturating at 32'hFFFFFFFF without wrapping.

Structure
REQ-022 A shared package SHALL hold the state encodings (IDLE=1'b0, HOLD=1'b1), the ZERO_REG=5'd0 constant, and the counter width of 32.
REQ-023 The source-match comparator of REQ-003 SHALL be a sub-module named mips_hazard_srcmatch, instantiated twice (for the EX and MEM destinations).

Verification
REQ-024 Load-use: MemReadEX=1, WriteRegEX=8, RsID=8 -> Stall=1 for exactly 1 cycle and PCWrite=IFIDWrite=0; the next cycle, with a bubble in EX, Stall=0.
REQ-025 Branch on load: BranchID=1, MemReadEX=1, WriteRegEX=9, RtID=9, UsesRtID=1 -> Stall=1 for exactly 2 cycles (IDLE, HOLD), then 0; StallCount advances by 2.
REQ-026 Register zero: MemReadEX=1, WriteRegEX=0, RsID=0 -> Stall=0.
REQ-027 Flush in HOLD: enter HOLD as in REQ-025, then FlushID=1 in cycle 2 -> Stall=0 that cycle and state=IDLE.
REQ-028 Reset mid-HOLD: reset pulsed in HOLD -> Stall=0 immediately and StallCount=0; following stimulus behaves as from power-up.
REQ-029 Saturation: preload StallCount to 32'hFFFFFFFE and apply 3 stall cycles -> StallCount reads 32'hFFFFFFFF.

Source files
------------

// File: rtl/mips_hazard_pkg.sv
// Shared definitions for the MIPS hazard unit.
//   state_e   : hazard FSM state encoding (IDLE / HOLD)
//   ZERO_REG  : architectural zero register index, never a real producer
//   CNT_W     : width of the optional stall-cycle counter
package mips_hazard_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [4:0] ZERO_REG = 5'd0;
  localparam int unsigned CNT_W = 32;

endpackage

// File: rtl/mips_hazard_srcmatch.sv
// Source-operand match: asserts when destination register dst_reg is a
// real register (not r0) and is read by the ID instruction, either as Rs
// or, when the instruction actually uses it, as Rt.
//   dst_reg  : producer destination register
//   rs_id    : Rs field of the ID instruction
//   rt_id    : Rt field of the ID instruction
//   uses_rt  : ID instruction reads Rt
//   match    : dst_reg feeds the ID instruction
module mips_hazard_srcmatch
  import mips_hazard_pkg::*;
(
  input  logic [4:0] dst_reg,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       uses_rt,
  output logic       match
);

  assign match = (dst_reg != ZERO_REG) &&
                 ((dst_reg == rs_id) || (uses_rt && (dst_reg == rt_id)));

endmodule

// File: rtl/mips_hazard_unit.sv
// MIPS pipeline hazard detection unit.
// Detects load-use and branch-in-ID data hazards and requests bubbles.
// A branch depending on a load still in EX needs two bubbles; the second
// one is supplied by the HOLD state. A flush of the ID instruction cancels
// any stall and any pending HOLD.
//   clk, reset     : clock, asynchronous active-high reset
//   *EX / *MEM     : producer info for the EX and MEM instructions
//   RsID/RtID/...  : consumer info for the ID instruction
//   Stall          : zero the ID control signals
//   PCWrite        : PC update enable (= ~Stall)
//   IFIDWrite      : IF/ID write enable (= ~Stall)
//   StallCount     : saturating stall-cycle counter, only when
//                    HAZARD_STALL_COUNT_EN is defined
module mips_hazard_unit
  import mips_hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       MemReadEX,
  input  logic       RegWriteEX,
  input  logic [4:0] WriteRegEX,
  input  logic       MemReadMEM,
  input  logic [4:0] WriteRegMEM,
  input  logic [4:0] RsID,
  input  logic [4:0] RtID,
  input  logic       UsesRtID,
  input  logic       BranchID,
  input  logic       FlushID,
  output logic       Stall,
  output logic       PCWrite,
  output logic       IFIDWrite
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [CNT_W-1:0] StallCount
`endif
);

  state_e state_q, state_d;
  logic   match_ex, match_mem;
  logic   load_use, br_alu, br_load_ex, br_load_mem, hazard;

  mips_hazard_srcmatch u_match_ex (
    .dst_reg (WriteRegEX),
    .rs_id   (RsID),
    .rt_id   (RtID),
    .uses_rt (UsesRtID),
    .match   (match_ex)
  );

  mips_hazard_srcmatch u_match_mem (
    .dst_reg (WriteRegMEM),
    .rs_id   (RsID),
    .rt_id   (RtID),
    .uses_rt (UsesRtID),
    .match   (match_mem)
  );

  // Detection depends on pipeline inputs only, never on Stall.
  assign load_use    = MemReadEX && match_ex;
  assign br_alu      = BranchID && RegWriteEX && !MemReadEX && match_ex;
  assign br_load_ex  = BranchID && MemReadEX && match_ex;
  assign br_load_mem = BranchID && MemReadMEM && match_mem;
  assign hazard      = load_use || br_alu || br_load_ex || br_load_mem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Only the two-cycle hazard enters HOLD, so overlapping hazards never
  // stall longer than two cycles.
  always_comb begin
    state_d = IDLE;
    if (!FlushID && state_q == IDLE && br_load_ex) state_d = HOLD;
  end

  // Reset and flush both dominate; HOLD dominates detection.
  always_comb begin
    Stall = 1'b0;
    if (reset || FlushID)    Stall = 1'b0;
    else if (state_q == HOLD) Stall = 1'b1;
    else                      Stall = hazard;
  end

  assign PCWrite   = !Stall;
  assign IFIDWrite = !Stall;

`ifdef HAZARD_STALL_COUNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign StallCount = stall_cnt_q;
`endif

endmodule
